spi_mem_arbiter: RTL and testbench

Shares the single external SPI RAM bus between the CPU's instruction-fetch port and its data port. Each granted request runs one complete 16-bit SPI RAM transaction: command, 24-bit address, then 16 data bits. Transactions are never interleaved. The block sits between the CPU core and the `spi_clk`/`spi_mosi`/`spi_select`/`spi_miso` pins.

---
 rtl/spi_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_spi_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI RAM bus between the CPU fetch and data ports; one 16-bit transaction per grant.
// Optional: define SPI_MEM_ROUND_ROBIN_EN for round-robin arbitration (default: data over fetch).
module spi_mem_arbiter #(
    parameter int         ADDR_W    = 24,
    parameter int         DATA_W    = 16,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              spi_select,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              busy
);
    localparam int FRAME_W = 8 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

    state_t             state, state_nxt;
    logic               phase;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] frame;
    logic [DATA_W-1:0]  rx;
    logic               sel_d;
    logic               we_q;
    logic               any_req;
    logic               grant_d;

    assign any_req = f_req | d_req;

`ifdef SPI_MEM_ROUND_ROBIN_EN
    // last_f = 1 means fetch was served last, so data wins the next tie
    logic last_f;
    assign grant_d = d_req & (~f_req | last_f);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_f <= 1'b1;
        else if (state == IDLE && any_req)
            last_f <= ~grant_d;
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = SHIFT;
            SHIFT:   if (phase && bit_cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pin outputs are registered decodes of the current state, so they trail it by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= 1'b0;
            bit_cnt    <= '0;
            frame      <= '0;
            rx         <= '0;
            sel_d      <= 1'b0;
            we_q       <= 1'b0;
            f_rdata    <= '0;
            d_rdata    <= '0;
            f_ack      <= 1'b0;
            d_ack      <= 1'b0;
            spi_select <= 1'b0;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            spi_select <= (state == SHIFT);
            spi_clk    <= (state == SHIFT) && phase;
            busy       <= (state != IDLE);
            f_ack      <= (state == DONE) && !sel_d;
            d_ack      <= (state == DONE) && sel_d;
            case (state)
                IDLE: if (any_req) begin
                    sel_d   <= grant_d;
                    we_q    <= grant_d & d_we;
                    phase   <= 1'b0;
                    bit_cnt <= CNT_W'(FRAME_W - 1);
                    if (grant_d)
                        frame <= {(d_we ? CMD_WRITE : CMD_READ), d_addr, d_wdata};
                    else
                        frame <= {CMD_READ, f_addr, {DATA_W{1'b0}}};
                end
                SHIFT: begin
                    phase <= ~phase;
                    if (!phase) begin
                        spi_mosi <= frame[FRAME_W-1];
                    end else begin
                        frame   <= frame << 1;
                        bit_cnt <= bit_cnt - 1'b1;
                        if (bit_cnt < CNT_W'(DATA_W))
                            rx <= {rx[DATA_W-2:0], spi_miso};
                    end
                end
                DONE: begin
                    spi_mosi <= 1'b0;
                    if (!we_q) begin
                        if (sel_d) d_rdata <= rx;
                        else       f_rdata <= rx;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: SPI RAM slave model, vector table, directed corner cases, random pairs.
`timescale 1ns/1ps
module tb_spi_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [23:0] f_addr = '0, d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] f_rdata, d_rdata;
    logic        f_ack, d_ack, spi_select, spi_clk, spi_mosi, busy;
    logic        spi_miso = 1'b0;

    int total = 0;
    int bad = 0;
    int inv_bad = 0;

    byte unsigned smem [0:1023];
    byte unsigned rmem [0:1023];
    logic [47:0]  cap = '0;
    logic [47:0]  last_frame = '0;
    int           last_bits = 0;
    int           rises = 0;
    logic [15:0]  rword = '0;
    logic [7:0]   rop = '0;

    logic [15:0]  m_frd, m_drd;
    bit           m_last_f;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [23:0] addr;
        logic [15:0] wd;
        logic [47:0] frame;
        logic [15:0] rd;
    } vec_t;
    vec_t vt [5];

    always #5 clk = ~clk;

    spi_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .spi_select(spi_select), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .busy(busy)
    );

    function automatic byte unsigned pat(input int i);
        if (i == 16) return 8'h12;
        if (i == 17) return 8'h34;
        return 8'(i * 37 + 11);
    endfunction

    function automatic bit winner_d(input bit pf, input bit pd);
`ifdef SPI_MEM_ROUND_ROBIN_EN
        return pd && (!pf || m_last_f);
`else
        return pd;
`endif
    endfunction

    // SPI RAM slave, sampled on the falling system clock
    initial begin : slave
        bit prev_sel, prev_sclk;
        int a;
        for (int i = 0; i < 1024; i++) smem[i] = pat(i);
        prev_sel = 0;
        prev_sclk = 0;
        forever begin
            @(negedge clk);
            if (!spi_select && spi_clk) inv_bad++;
            if (spi_select && !prev_sel) begin
                rises = 0;
                cap = '0;
                prev_sclk = 0;
            end
            if (spi_select) begin
                if (spi_clk && !prev_sclk) begin
                    cap = {cap[46:0], spi_mosi};
                    rises++;
                    if (rises == 32) begin
                        rop = cap[31:24];
                        a = int'(cap[9:0]);
                        rword = {smem[a], smem[a+1]};
                    end
                end else if (!spi_clk && prev_sclk && rises >= 32 && rises < 48 && rop == 8'h03) begin
                    spi_miso = rword[15 - (rises - 32)];
                end
                prev_sclk = spi_clk;
            end else if (prev_sel) begin
                last_frame = cap;
                last_bits = rises;
                if (rises == 48 && cap[47:40] == 8'h02) begin
                    a = int'(cap[25:16]);
                    smem[a]   = cap[15:8];
                    smem[a+1] = cap[7:0];
                end
                spi_miso = 1'b0;
            end
            prev_sel = spi_select;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Raise the requested ports, serve each grant in model order and check every completion.
    task automatic run(input bit fr, input bit dr, input bit dwe, input logic [23:0] fa,
                       input logic [23:0] da, input logic [15:0] dwd, input int drop_k);
        bit pend_f, pend_d, first, got, exp_d, we_;
        int k, a;
        f_addr = fa; d_addr = da; d_we = dwe; d_wdata = dwd;
        f_req = fr; d_req = dr;
        pend_f = fr; pend_d = dr; first = 1;
        while (pend_f || pend_d) begin
            exp_d = winner_d(pend_f, pend_d);
            k = 0; got = 0;
            while (!got && k < 150) begin
                @(posedge clk); #1;
                k++;
                if (first && k == drop_k) d_req = 1'b0;
                if (first && k == 2) begin
                    chk("busy_rise", 64'(busy), 64'(1));
                    chk("sel_rise", 64'(spi_select), 64'(1));
                    chk("sclk_first_low", 64'(spi_clk), 64'(0));
                end
                if (first && k == 3) chk("sclk_first_high", 64'(spi_clk), 64'(1));
                if (!first && k <= 2) chk("sel_gap", 64'(spi_select), 64'(0));
                if (f_ack || d_ack) got = 1;
            end
            chk("ack_latency", 64'(k), 64'(first ? 98 : 99));
            chk("ack_port", 64'({f_ack, d_ack}), 64'(exp_d ? 2'b01 : 2'b10));
            if (!got) begin
                f_req = 1'b0; d_req = 1'b0;
                return;
            end
            if (exp_d) begin pend_d = 0; d_req = 1'b0; end
            else begin pend_f = 0; f_req = 1'b0; end
            m_last_f = !exp_d;
            a = exp_d ? int'(da[9:0]) : int'(fa[9:0]);
            we_ = exp_d && dwe;
            if (we_) begin
                rmem[a] = dwd[15:8];
                rmem[a+1] = dwd[7:0];
            end else if (exp_d) begin
                m_drd = {rmem[a], rmem[a+1]};
            end else begin
                m_frd = {rmem[a], rmem[a+1]};
            end
            chk("f_rdata", 64'(f_rdata), 64'(m_frd));
            chk("d_rdata", 64'(d_rdata), 64'(m_drd));
            chk("busy_at_ack", 64'(busy), 64'(1));
            chk("sel_at_ack", 64'({spi_select, spi_clk}), 64'(0));
            @(negedge clk); #1;
            chk("frame_bits", 64'(last_bits), 64'(48));
            chk("frame_hdr", 64'(last_frame[47:16]),
                64'({(we_ ? 8'h02 : 8'h03), (exp_d ? da : fa)}));
            if (we_) chk("frame_wdata", 64'(last_frame[15:0]), 64'(dwd));
            first = 0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int k, acks;
        bit fr, dr;
        logic [23:0] fa, da;
        for (int i = 0; i < 1024; i++) rmem[i] = pat(i);
        m_frd = '0; m_drd = '0; m_last_f = 1;

        vt[0] = '{is_d: 0, we: 0, addr: 24'h000010, wd: 16'h0, frame: 48'h030000100000, rd: 16'h1234};
        vt[1] = '{is_d: 1, we: 1, addr: 24'h000200, wd: 16'hBEEF, frame: 48'h02000200BEEF, rd: 16'h0};
        vt[2] = '{is_d: 1, we: 0, addr: 24'h000200, wd: 16'h0, frame: 48'h030002000000, rd: 16'hBEEF};
        vt[3] = '{is_d: 0, we: 0, addr: 24'h000200, wd: 16'h0, frame: 48'h030002000000, rd: 16'hBEEF};
        vt[4] = '{is_d: 1, we: 0, addr: 24'h000010, wd: 16'h0, frame: 48'h030000100000, rd: 16'h1234};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pins", 64'({spi_select, spi_clk, spi_mosi, busy}), 64'(0));
        chk("rst_acks", 64'({f_ack, d_ack}), 64'(0));
        chk("rst_rdata", 64'({f_rdata, d_rdata}), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            run(!vt[i].is_d, vt[i].is_d, vt[i].we, vt[i].addr, vt[i].addr, vt[i].wd, 0);
            chk("vec_hdr", 64'(last_frame[47:16]), 64'(vt[i].frame[47:16]));
            if (vt[i].we) begin
                chk("vec_wdata", 64'(last_frame[15:0]), 64'(vt[i].frame[15:0]));
                chk("vec_f_kept", 64'(f_rdata), 64'(16'h1234));
            end else begin
                chk("vec_rdata", 64'(vt[i].is_d ? d_rdata : f_rdata), 64'(vt[i].rd));
            end
        end

        // simultaneous requests, then a data request withdrawn at bit 30
        run(1, 1, 0, 24'h000010, 24'h000200, 16'h0, 0);
        run(0, 1, 0, 24'h0, 24'h000010, 16'h0, 36);

        // reset during address bit 20 of a fetch
        f_addr = 24'h000010; f_req = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        chk("pre_reset_sel", 64'(spi_select), 64'(1));
        rst_n = 1'b0;
        f_req = 1'b0;
        #1;
        chk("async_rst_pins", 64'({spi_select, spi_clk, busy}), 64'(0));
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            acks += int'(f_ack) + int'(d_ack);
        end
        chk("rst_no_ack", 64'(acks), 64'(0));
        chk("rst_rdata_clr", 64'({f_rdata, d_rdata}), 64'(0));
        m_frd = '0; m_drd = '0; m_last_f = 1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run(1, 0, 0, 24'h000010, 24'h0, 16'h0, 0);
        chk("post_rst_fetch", 64'(f_rdata), 64'(16'h1234));

        // random traffic over a small address window so reads hit earlier writes
        for (int i = 0; i < 24; i++) begin
            fr = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!fr && !dr) dr = 1;
            fa = 24'(256 + 2 * $urandom_range(0, 7));
            da = 24'(256 + 2 * $urandom_range(0, 7));
            run(fr, dr, 1'($urandom_range(0, 1)), fa, da, 16'($urandom), 0);
        end

        chk("sclk_low_when_deselected", 64'(inv_bad), 64'(0));
        k = total;
        $display("test done: total=%0d bad=%0d", k, bad);
        $finish;
    end
endmodule
